// File: rtl/cpu_step_ctrl_pkg.sv
// Shared state type and mode encodings for the CPU single-step / run / burst controller.
package cpu_step_ctrl_pkg;

  localparam logic [1:0] MODE_HALT  = 2'd0;
  localparam logic [1:0] MODE_STEP  = 2'd1;
  localparam logic [1:0] MODE_RUN   = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    S_HALT  = MODE_HALT,
    S_STEP  = MODE_STEP,
    S_RUN   = MODE_RUN,
    S_BURST = MODE_BURST
  } state_t;

endpackage

// File: rtl/step_ctrl_counters.sv
// Retired-instruction counter (wrapping) and burst down-counter; 1-cycle update, no backpressure.
module step_ctrl_counters #(
  parameter int BURST_W = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               inc,
  input  logic               load,
  input  logic [BURST_W-1:0] load_val,
  input  logic               dec,
  input  logic               clr,
  output logic [31:0]        retired_cnt,
  output logic [BURST_W-1:0] burst_cnt
);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      retired_cnt <= '0;
      burst_cnt   <= '0;
    end else begin
      if (inc) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      // An abort wins over a same-cycle load or decrement.
      if (clr) begin
        burst_cnt <= '0;
      end else if (load) begin
        burst_cnt <= load_val;
      end else if (dec) begin
        burst_cnt <= burst_cnt - BURST_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Debug execution controller: halt / single-step / free-run / burst with a PC breakpoint.
// Commands from HALT take effect on the next edge; cpu_en is registered.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int BURST_W = 8,
  parameter int PC_W    = 32
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               step_p,
  input  logic               run_p,
  input  logic               halt_p,
  input  logic               burst_p,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               retire,
  input  logic [PC_W-1:0]    pc,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  output logic               cpu_en,
  output logic [1:0]         mode,
  output logic               bp_hit,
  output logic [31:0]        retired_cnt
);

  state_t             state;
  state_t             state_nxt;
  logic [BURST_W-1:0] burst_cnt;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_clr;
  logic               bp_set;
  logic               bp_clr;
  logic               ret_vld;
  logic               bp_cond;

  // A retire only counts while the CPU is actually enabled.
  assign ret_vld = retire && cpu_en;
  // Stop before the instruction at bp_addr is requested, not after it retires.
  assign bp_cond = bp_en && (pc == bp_addr) && !retire;

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;
    bp_set    = 1'b0;
    bp_clr    = 1'b0;
    case (state)
      S_HALT: begin
        if (halt_p) begin
          state_nxt = S_HALT;
        end else if (run_p) begin
          state_nxt = S_RUN;
          bp_clr    = 1'b1;
        end else if (step_p) begin
          state_nxt = S_STEP;
          bp_clr    = 1'b1;
        end else if (burst_p && (burst_len != '0)) begin
          state_nxt = S_BURST;
          cnt_load  = 1'b1;
          bp_clr    = 1'b1;
        end
      end
      S_STEP: begin
        if (halt_p || ret_vld) begin
          state_nxt = S_HALT;
        end
      end
      S_RUN: begin
        bp_set = bp_cond;
        if (bp_cond || halt_p) begin
          state_nxt = S_HALT;
        end
      end
      S_BURST: begin
        bp_set = bp_cond;
        if (bp_cond || halt_p) begin
          state_nxt = S_HALT;
          cnt_clr   = 1'b1;
        end else if (ret_vld) begin
          cnt_dec = 1'b1;
          if (burst_cnt == BURST_W'(1)) begin
            state_nxt = S_HALT;
          end
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_HALT;
      cpu_en <= 1'b0;
      bp_hit <= 1'b0;
    end else begin
      state  <= state_nxt;
      cpu_en <= (state_nxt != S_HALT);
      if (bp_set) begin
        bp_hit <= 1'b1;
      end else if (bp_clr) begin
        bp_hit <= 1'b0;
      end
    end
  end

  assign mode = state;

  step_ctrl_counters #(
    .BURST_W (BURST_W)
  ) u_cnt (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .inc         (ret_vld),
    .load        (cnt_load),
    .load_val    (burst_len),
    .dec         (cnt_dec),
    .clr         (cnt_clr),
    .retired_cnt (retired_cnt),
    .burst_cnt   (burst_cnt)
  );

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed scoreboard bench for cpu_step_ctrl: expectations queued at stimulus, popped at checks.
module tb_cpu_step_ctrl;

  logic        Clock;
  logic        Reset_n;
  logic        step_p;
  logic        run_p;
  logic        halt_p;
  logic        burst_p;
  logic [7:0]  burst_len;
  logic        retire;
  logic [31:0] pc;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        cpu_en;
  logic [1:0]  mode;
  logic        bp_hit;
  logic [31:0] retired_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt;

  cpu_step_ctrl #(
    .BURST_W (8),
    .PC_W    (32)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .step_p      (step_p),
    .run_p       (run_p),
    .halt_p      (halt_p),
    .burst_p     (burst_p),
    .burst_len   (burst_len),
    .retire      (retire),
    .pc          (pc),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .cpu_en      (cpu_en),
    .mode        (mode),
    .bp_hit      (bp_hit),
    .retired_cnt (retired_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=0x%0h required=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=0x%0h required=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int n;
    int bp_cyc;
    logic did_ret;

    Reset_n = 1'b0; step_p = 0; run_p = 0; halt_p = 0; burst_p = 0;
    burst_len = '0; retire = 0; pc = '0; bp_en = 0; bp_addr = '0;
    exp_cnt = 32'd0;
    #2;
    push("rst_cpu_en", 0); check(32'(cpu_en));
    push("rst_mode", 0);   check(32'(mode));
    push("rst_bp_hit", 0); check(32'(bp_hit));
    push("rst_cnt", 0);    check(retired_cnt);
    #10 Reset_n = 1'b1;
    tick();

    // Single step: retire three cycles after the pulse.
    step_p = 1; tick(); step_p = 0;
    push("step_mode", 1); check(32'(mode));
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      if (cpu_en) hi++;
      if (i == 2) retire = 1;
      tick();
    end
    retire = 0;
    exp_cnt = exp_cnt + 1;
    push("step_en_cycles", 3); check(32'(hi));
    push("step_en_after", 0);  check(32'(cpu_en));
    push("step_mode_after", 0); check(32'(mode));
    push("step_cnt", exp_cnt); check(retired_cnt);

    // Burst of 5 with retire every cycle.
    burst_len = 8'd5; burst_p = 1; tick(); burst_p = 0;
    push("burst_mode", 3); check(32'(mode));
    retire = 1; n = 0;
    while (cpu_en && n < 20) begin n++; tick(); end
    retire = 0;
    exp_cnt = exp_cnt + 5;
    push("burst_en_cycles", 5); check(32'(n));
    push("burst_mode_after", 0); check(32'(mode));
    push("burst_cnt", exp_cnt); check(retired_cnt);

    // Zero-length burst is a no-op.
    burst_len = 8'd0; burst_p = 1; tick(); burst_p = 0;
    push("burst0_en", 0); check(32'(cpu_en));
    tick();
    push("burst0_en_later", 0); check(32'(cpu_en));

    // Free run into a breakpoint at 0x10; two-cycle-per-instruction CPU model.
    bp_en = 1; bp_addr = 32'h10; pc = 32'h0;
    run_p = 1; tick(); run_p = 0;
    push("run_mode", 2); check(32'(mode));
    n = 0; bp_cyc = 0; did_ret = 0;
    while (cpu_en && n < 40) begin
      if (pc == 32'h10) bp_cyc++;
      retire = (n % 2 == 1);
      did_ret = retire;
      tick();
      if (did_ret) pc = pc + 32'd4;
      n++;
    end
    retire = 0;
    exp_cnt = exp_cnt + 4;
    push("bp_en_cycles_at_bp", 1); check(32'(bp_cyc));
    push("bp_stop_pc", 32'h10);    check(pc);
    push("bp_hit_set", 1);         check(32'(bp_hit));
    push("bp_cnt", exp_cnt);       check(retired_cnt);

    // Step off the breakpoint.
    step_p = 1; tick(); step_p = 0;
    push("bp_hit_clr", 0); check(32'(bp_hit));
    push("bp_step_mode", 1); check(32'(mode));
    retire = 1; tick(); retire = 0; pc = pc + 32'd4;
    exp_cnt = exp_cnt + 1;
    push("bp_step_en", 0); check(32'(cpu_en));
    push("bp_step_cnt", exp_cnt); check(retired_cnt);
    bp_en = 0;

    // Retire while halted is ignored.
    retire = 1; tick(); tick(); retire = 0;
    push("halt_retire_cnt", exp_cnt); check(retired_cnt);
    push("halt_retire_mode", 0); check(32'(mode));

    // Simultaneous pulses.
    halt_p = 1; run_p = 1; tick(); halt_p = 0; run_p = 0;
    push("halt_run_mode", 0); check(32'(mode));
    run_p = 1; step_p = 1; tick(); run_p = 0; step_p = 0;
    push("run_step_mode", 2); check(32'(mode));
    halt_p = 1; tick(); halt_p = 0;
    push("run_halt_mode", 0); check(32'(mode));
    burst_len = 8'd8; burst_p = 1; tick(); burst_p = 0;
    retire = 1; tick();
    halt_p = 1; tick(); halt_p = 0; retire = 0;
    exp_cnt = exp_cnt + 2;
    push("bhalt_mode", 0); check(32'(mode));
    push("bhalt_en", 0); check(32'(cpu_en));
    push("bhalt_cnt", exp_cnt); check(retired_cnt);
    push("bhalt_burst_cnt", 0); check(32'(dut.u_cnt.burst_cnt));

    // Halt and breakpoint in the same cycle still flag the breakpoint.
    bp_en = 1; bp_addr = 32'h40; pc = 32'h40;
    run_p = 1; tick(); run_p = 0;
    halt_p = 1; tick(); halt_p = 0; bp_en = 0;
    push("halt_bp_mode", 0); check(32'(mode));
    push("halt_bp_hit", 1); check(32'(bp_hit));

    // Reset in the middle of a long burst.
    burst_len = 8'd200; burst_p = 1; tick(); burst_p = 0;
    retire = 1;
    repeat (10) tick();
    exp_cnt = exp_cnt + 10;
    push("preRst_cnt", exp_cnt); check(retired_cnt);
    #2 Reset_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    push("arst_en", 0); check(32'(cpu_en));
    push("arst_mode", 0); check(32'(mode));
    push("arst_cnt", 0); check(retired_cnt);
    push("arst_burst_cnt", 0); check(32'(dut.u_cnt.burst_cnt));
    #3 Reset_n = 1'b1;
    tick(); tick(); tick();
    retire = 0;
    push("postRst_en", 0); check(32'(cpu_en));
    push("postRst_cnt", 0); check(retired_cnt);

    // Counter wrap.
    force dut.u_cnt.retired_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.u_cnt.retired_cnt;
    #1;
    push("wrap_preload", 32'hFFFF_FFFE); check(retired_cnt);
    run_p = 1; tick(); run_p = 0;
    retire = 1; tick(); tick(); tick(); retire = 0;
    halt_p = 1; tick(); halt_p = 0;
    push("wrap_cnt", 32'h0000_0001); check(retired_cnt);
    push("wrap_mode", 0); check(32'(mode));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
